// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmit path.
//   - state_t       : transmitter FSM encodings
//   - FRAME_EDGES   : device falling edges per host-to-device frame (incl. ACK)
//   - CMD_*         : common keyboard command bytes
//   - *_DEF         : default timing for a 65 MHz system clock
//   - max3()        : helper for sizing shared counters
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5,
        WAIT_IDLE = 3'd6
    } state_t;

    localparam int FRAME_EDGES = 11;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;

    localparam int INHIBIT_CYC_DEF       = 7800;    // 120 us
    localparam int START_TIMEOUT_CYC_DEF = 975000;  // 15 ms
    localparam int BIT_TIMEOUT_CYC_DEF   = 130000;  // 2 ms
    localparam int FILTER_LEN_DEF        = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 pad signal.
//   clk, rst : system clock, async active-high reset
//   pad      : raw pad value
//   level    : filtered line level (resets to 1 = released)
//   fall     : one-cycle pulse when level goes 1 -> 0
// Pad-to-fall latency is 2 (synchroniser) + FILTER_LEN cycles.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN) + 1;

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b1;
            sync  <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            meta <= pad;
            sync <= meta;
            fall <= 1'b0;
            // Any return to the current level restarts the count, so a
            // glitch shorter than FILTER_LEN cycles never reaches level.
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync;
                fall  <= ~sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter (one command byte per frame).
//   clk, rst        : 65 MHz system clock, async active-high reset
//   tx_data/valid   : command byte request
//   tx_ready        : high only in IDLE
//   busy            : high whenever a transmission is in progress
//   done            : one-cycle pulse when a frame completes
//   ack_err         : pulses with done when the device did not ACK
//   timeout         : one-cycle pulse when the frame is aborted
//   ps2_clk_in/_oe  : clock pad value / drive-low enable (open drain)
//   ps2_data_in/_oe : data pad value / drive-low enable (open drain)
//   dbg_state       : current FSM state (state_t encoding)
//   dbg_edge_cnt    : device falling edges counted in this frame
//
// Handshake: a byte is taken on any cycle where tx_valid && tx_ready; the
// client may hold tx_valid, and requests while not ready are dropped.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC       = INHIBIT_CYC_DEF,
    parameter int START_TIMEOUT_CYC = START_TIMEOUT_CYC_DEF,
    parameter int BIT_TIMEOUT_CYC   = BIT_TIMEOUT_CYC_DEF,
    parameter int FILTER_LEN        = FILTER_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic [2:0] dbg_state,
    output logic [3:0] dbg_edge_cnt
);

    // One counter serves as the inhibit timer and the watchdog.
    localparam int WD_W = $clog2(max3(INHIBIT_CYC, START_TIMEOUT_CYC, BIT_TIMEOUT_CYC) + 1);

    state_t            state, state_d;
    logic [7:0]        sh, sh_d;
    logic              par_q, par_d;
    logic [3:0]        edge_cnt, edge_d, edge_next;
    logic              data_oe_q, data_oe_d;
    logic              ack_bit, ack_d;
    logic [WD_W-1:0]   wd;
    logic              abort, inhibit_last, wd_clr;
    logic              clk_level, clk_fall, data_level, data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk(clk), .rst(rst), .pad(ps2_clk_in), .level(clk_level), .fall(clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk(clk), .rst(rst), .pad(ps2_data_in), .level(data_level), .fall(data_fall_unused)
    );

    assign edge_next = edge_cnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d      = state;
        sh_d         = sh;
        par_d        = par_q;
        edge_d       = edge_cnt;
        data_oe_d    = data_oe_q;
        ack_d        = ack_bit;
        abort        = 1'b0;
        inhibit_last = 1'b0;
        tx_ready     = 1'b0;
        done         = 1'b0;
        ack_err      = 1'b0;
        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    sh_d      = tx_data;
                    par_d     = ~^tx_data;
                    edge_d    = 4'd0;
                    data_oe_d = 1'b0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (wd == WD_W'(INHIBIT_CYC - 1)) begin
                    inhibit_last = 1'b1;
                    data_oe_d    = 1'b1;   // start bit
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (clk_fall) begin
                    data_oe_d = ~sh[0];
                    sh_d      = {1'b0, sh[7:1]};
                    edge_d    = 4'd1;
                    state_d   = DATA;
                end else if (wd == WD_W'(START_TIMEOUT_CYC)) begin
                    abort = 1'b1;
                end
            end
            DATA: begin
                if (clk_fall) begin
                    edge_d = edge_next;
                    if (edge_next == 4'(FRAME_EDGES - 2)) begin
                        data_oe_d = ~par_q;
                        state_d   = PARITY;
                    end else begin
                        data_oe_d = ~sh[0];
                        sh_d      = {1'b0, sh[7:1]};
                    end
                end else if (wd == WD_W'(BIT_TIMEOUT_CYC)) begin
                    abort = 1'b1;
                end
            end
            PARITY: begin
                if (clk_fall) begin
                    edge_d    = edge_next;
                    data_oe_d = 1'b0;      // stop bit: release data
                    state_d   = STOP;
                end else if (wd == WD_W'(BIT_TIMEOUT_CYC)) begin
                    abort = 1'b1;
                end
            end
            STOP: begin
                if (clk_fall) begin
                    edge_d  = edge_next;
                    ack_d   = data_level;  // device pulls data low to ACK
                    state_d = WAIT_IDLE;
                end else if (wd == WD_W'(BIT_TIMEOUT_CYC)) begin
                    abort = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (clk_level && data_level) begin
                    done    = 1'b1;
                    ack_err = ack_bit;
                    state_d = IDLE;
                end else if (wd == WD_W'(BIT_TIMEOUT_CYC)) begin
                    abort = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            data_oe_d = 1'b0;
            state_d   = IDLE;
        end
    end

    // The host's own clock pull in INHIBIT produces a filtered fall; it must
    // not restart the inhibit timer.
    assign wd_clr = (state_d != state) || (clk_fall && state != INHIBIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh        <= '0;
            par_q     <= 1'b0;
            edge_cnt  <= '0;
            data_oe_q <= 1'b0;
            ack_bit   <= 1'b0;
            wd        <= '0;
        end else begin
            sh        <= sh_d;
            par_q     <= par_d;
            edge_cnt  <= edge_d;
            data_oe_q <= data_oe_d;
            ack_bit   <= ack_d;
            if (wd_clr || state == IDLE) wd <= '0;
            else if (wd != '1)           wd <= wd + 1'b1;
        end
    end

    assign timeout      = abort;
    assign busy         = (state != IDLE);
    assign ps2_clk_oe   = (state == INHIBIT);
    assign ps2_data_oe  = data_oe_q | inhibit_last;
    assign dbg_state    = state;
    assign dbg_edge_cnt = edge_cnt;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table-driven bench for ps2_host_tx with a PS/2 device model
// on the open-drain lines, plus hand sequences for glitch, reset and
// abort/request overlap. Timing parameters are shortened for simulation.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH      = 50;
    localparam int START_TO = 600;
    localparam int BIT_TO   = 300;
    localparam int FL       = 8;
    localparam int HALF     = 30;   // device clock half period in cycles

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, ack_err, timeout;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic [2:0] dbg_state;
    logic [3:0] dbg_edge_cnt;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYC(INH), .START_TIMEOUT_CYC(START_TO),
        .BIT_TIMEOUT_CYC(BIT_TO), .FILTER_LEN(FL)
    ) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .ack_err(ack_err),
        .timeout(timeout), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .dbg_state(dbg_state), .dbg_edge_cnt(dbg_edge_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- monitor ----------------
    int         inh_run = 0, last_inh = 0;
    int         done_cnt = 0, to_cnt = 0;
    int         to_cyc = 0, req_cyc = 0, edge_cyc = 0;
    bit         ack_err_last = 1'b0;
    logic [2:0] prev_state = 3'd0;
    logic [3:0] prev_edge = 4'd0;

    always @(negedge clk) begin
        if (ps2_clk_oe) inh_run++;
        else if (inh_run != 0) begin
            last_inh = inh_run;
            inh_run  = 0;
        end
        if (done) begin
            done_cnt++;
            ack_err_last = ack_err;
        end
        if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (dbg_state == 3'(REQ) && prev_state != 3'(REQ)) req_cyc = cyc;
        if (dbg_edge_cnt != prev_edge) edge_cyc = cyc;
        prev_state = dbg_state;
        prev_edge  = dbg_edge_cnt;
    end

    // ---------------- scoreboard ----------------
    int          total = 0, bad = 0;
    logic [10:0] exp_q[$];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        check("ready_before_send", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Device model: samples data on every rising line edge (the first one is
    // the host releasing clk), generates n_edges falls, and ACKs if asked.
    task automatic dev_frame(input int n_edges, input bit ack,
                             output logic [10:0] bits, output bit ok);
        int t;
        ok   = 1'b1;
        bits = '0;
        t = 0;
        while (!ps2_clk_oe && t < 1000) begin @(negedge clk); t++; end
        if (!ps2_clk_oe) ok = 1'b0;
        t = 0;
        while (ps2_clk_oe && t < 1000) begin @(negedge clk); t++; end
        if (ps2_clk_oe) ok = 1'b0;
        bits[0] = ps2_data_in;
        for (int k = 1; k <= n_edges; k++) begin
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k] = ps2_data_in;
            if (k == 10 && ack) dev_data_low = 1'b1;
        end
        if (n_edges == FRAME_EDGES) begin
            repeat (HALF) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0]  data;
        int          n_edges;
        bit          ack;
        bit          exp_done;
        bit          exp_to;
        logic [10:0] exp_bits;   // bit i = i-th sampled value (start first)
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [10:0] bits;
        bit          ok;
        int          d0, t0;

        vecs[0] = '{data:CMD_SET_LEDS, n_edges:11, ack:1'b1, exp_done:1'b1, exp_to:1'b0, exp_bits:11'h7DA};
        vecs[1] = '{data:8'h01,        n_edges:11, ack:1'b0, exp_done:1'b1, exp_to:1'b0, exp_bits:11'h402};
        vecs[2] = '{data:CMD_RESET,    n_edges:0,  ack:1'b0, exp_done:1'b0, exp_to:1'b1, exp_bits:11'h000};
        vecs[3] = '{data:8'h00,        n_edges:4,  ack:1'b0, exp_done:1'b0, exp_to:1'b1, exp_bits:11'h000};
        vecs[4] = '{data:8'h55,        n_edges:11, ack:1'b1, exp_done:1'b1, exp_to:1'b0, exp_bits:11'h6AA};
        vecs[5] = '{data:8'hA0,        n_edges:11, ack:1'b1, exp_done:1'b1, exp_to:1'b0, exp_bits:11'h740};
        vecs[6] = '{data:CMD_RESET,    n_edges:11, ack:1'b1, exp_done:1'b1, exp_to:1'b0, exp_bits:11'h7FE};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // Reset asserted mid-idle takes effect without a clock edge.
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("idle_rst_tx_ready", tx_ready, 1);
        check("idle_rst_busy", busy, 0);
        check("idle_rst_state", dbg_state, 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt;
            t0 = to_cnt;
            if (vecs[i].exp_done) exp_q.push_back(vecs[i].exp_bits);
            send_byte(vecs[i].data);
            dev_frame(vecs[i].n_edges, vecs[i].ack, bits, ok);
            check("dev_saw_release", ok, 1);
            wait_ready(2000, ok);
            check("back_to_idle", ok, 1);
            check("inhibit_len", last_inh, INH);
            check("done_pulses", done_cnt - d0, vecs[i].exp_done);
            check("timeout_pulses", to_cnt - t0, vecs[i].exp_to);
            if (vecs[i].exp_done) begin
                check("frame_bits", int'(bits), int'(exp_q.pop_front()));
                check("ack_err", ack_err_last, vecs[i].ack ? 0 : 1);
            end else if (vecs[i].n_edges == 0) begin
                check("start_timeout_gap", to_cyc - req_cyc, START_TO);
            end else begin
                check("bit_timeout_gap", to_cyc - edge_cyc, BIT_TO);
            end
            check("clk_oe_released", ps2_clk_oe, 0);
            check("data_oe_released", ps2_data_oe, 0);
            repeat (5) @(negedge clk);
        end

        // Glitch on clk during DATA, ignored request while busy, then reset.
        send_byte(8'h55);
        dev_frame(3, 1'b0, bits, ok);
        check("glitch_dev_release", ok, 1);
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (2 * FL + 5) @(negedge clk);
        check("glitch_edge_cnt", dbg_edge_cnt, 3);
        check("glitch_state", dbg_state, 32'(DATA));
        tx_data  = 8'h12;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        check("busy_ignore_state", dbg_state, 32'(DATA));
        check("busy_ignore_edges", dbg_edge_cnt, 3);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        check("fourth_edge", dbg_edge_cnt, 4);
        check("data_oe_d3", ps2_data_oe, 1);
        #2 rst = 1'b1;
        #1;
        check("data_rst_clk_oe", ps2_clk_oe, 0);
        check("data_rst_data_oe", ps2_data_oe, 0);
        check("data_rst_state", dbg_state, 32'(IDLE));
        check("data_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Request held across a start timeout: IDLE first, accept next cycle.
        send_byte(CMD_RESET);
        ok = 1'b0;
        for (int k = 0; k < INH + 20; k++) begin
            @(negedge clk);
            if (dbg_state == 3'(REQ)) begin ok = 1'b1; break; end
        end
        check("reached_req", ok, 1);
        tx_data  = CMD_SET_LEDS;
        tx_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < START_TO + 20; k++) begin
            @(negedge clk);
            if (timeout) begin ok = 1'b1; break; end
        end
        check("abort_seen", ok, 1);
        @(negedge clk);
        check("abort_then_idle", dbg_state, 32'(IDLE));
        check("abort_ready", tx_ready, 1);
        check("abort_data_oe", ps2_data_oe, 0);
        @(negedge clk);
        tx_valid = 1'b0;
        check("accept_after_abort", dbg_state, 32'(INHIBIT));
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "bench time limit");
    end

endmodule
